// File: rtl/maxpool2_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool2_stage_if
//  Description : Control handshake and RAM read/write bus of the 2x2 max-pool
//                stage. The stage itself is the master. The sequencer and
//                RAM side is the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface maxpool2_stage_if;
  logic        start_pool;
  logic        end_pool;
  logic [15:0] ram_addr_r;
  logic        ram_en_r;
  logic [7:0]  ram_data_r;
  logic [15:0] ram_addr_w;
  logic [7:0]  ram_data_w;
  logic        ram_en;
  logic        ram_wea;

  modport master (
    input  start_pool,
    input  ram_data_r,
    output end_pool,
    output ram_addr_r,
    output ram_en_r,
    output ram_addr_w,
    output ram_data_w,
    output ram_en,
    output ram_wea
  );

  modport slave (
    output start_pool,
    output ram_data_r,
    input  end_pool,
    input  ram_addr_r,
    input  ram_en_r,
    input  ram_addr_w,
    input  ram_data_w,
    input  ram_en,
    input  ram_wea
  );
endinterface
`default_nettype wire

// File: rtl/maxpool2_stage.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool2_stage
//  Description : 2x2 stride-2 signed max-pool over an IN_DIM x IN_DIM x CH
//                int8 map. Each window takes 4 reads, RD_LAT drain cycles and
//                1 write, which is 7 cycles at RD_LAT=2. A 4-cycle end_pool
//                burst follows the last write.
//  Revision    : 1.0  initial release
// ============================================================================
module maxpool2_stage #(
  parameter int          IN_DIM   = 20,
  parameter int          CH       = 16,
  parameter logic [15:0] OUT_BASE = 16'h8000,
  parameter int          RD_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  maxpool2_stage_if.master bus
);

  localparam int OD = IN_DIM / 2;
  localparam int XW = (OD > 1) ? $clog2(OD) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [XW-1:0] XY_LAST = XW'(OD - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(RD_LAT - 1);

  localparam logic [15:0] ROW    = 16'(IN_DIM);
  localparam logic [15:0] PLANE  = 16'(IN_DIM * IN_DIM);
  localparam logic [15:0] OROW   = 16'(OD);
  localparam logic [15:0] OPLANE = 16'(OD * OD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state;
  logic [XW-1:0]         ox;
  logic [XW-1:0]         oy;
  logic [CW-1:0]         ch;
  logic [1:0]            rcnt;
  logic [DW-1:0]         dcnt;
  logic [1:0]            ecnt;

  logic [XW-1:0]         ox_nx;
  logic [XW-1:0]         oy_nx;
  logic [CW-1:0]         ch_nx;
  logic                  last_win;
  logic [15:0]           base_cur;
  logic [15:0]           base_nx;
  logic [15:0]           out_idx;

  logic [RD_LAT-1:0]     vpipe;
  logic [RD_LAT-1:0]     fpipe;
  logic signed [7:0]     sample;
  logic signed [7:0]     max_q;
  logic signed [7:0]     max_nx;

  // Top-left input address of window (x, y, c).
  function automatic logic [15:0] win_base(input logic [XW-1:0] x,
                                           input logic [XW-1:0] y,
                                           input logic [CW-1:0] c);
    return (16'(x) << 1) + ((16'(y) * ROW) << 1) + 16'(c) * PLANE;
  endfunction

  // Offset of the k-th read within a window: TL, TR, BL, BR.
  function automatic logic [15:0] rd_offset(input logic [1:0] k);
    case (k)
      2'd0:    rd_offset = 16'd0;
      2'd1:    rd_offset = 16'd1;
      2'd2:    rd_offset = ROW;
      default: rd_offset = ROW + 16'd1;
    endcase
  endfunction

  // Next window indices, with ox fastest, then oy, then ch.
  always_comb begin
    ox_nx = ox;
    oy_nx = oy;
    ch_nx = ch;
    if (ox != XY_LAST) begin
      ox_nx = ox + 1'b1;
    end else begin
      ox_nx = '0;
      if (oy != XY_LAST) begin
        oy_nx = oy + 1'b1;
      end else begin
        oy_nx = '0;
        ch_nx = ch + 1'b1;
      end
    end
  end

  assign last_win = (ox == XY_LAST) && (oy == XY_LAST) && (ch == CH_LAST);
  assign base_cur = win_base(ox, oy, ch);
  assign base_nx  = win_base(ox_nx, oy_nx, ch_nx);
  assign out_idx  = 16'(ox) + 16'(oy) * OROW + 16'(ch) * OPLANE;
  assign sample   = bus.ram_data_r;

  // Running max. The first sample of a window loads it unconditionally;
  // later samples replace it only when strictly greater.
  always_comb begin
    max_nx = max_q;
    if (vpipe[RD_LAT-1]) begin
      if (fpipe[RD_LAT-1] || (sample > max_q)) begin
        max_nx = sample;
      end
    end
  end

  // Delay the read-issue and first-read markers by RD_LAT so they line up
  // with the returning data, and capture into the max register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      fpipe <= '0;
      max_q <= '0;
    end else begin
      vpipe[0] <= bus.ram_en_r;
      fpipe[0] <= bus.ram_en_r && (rcnt == 2'd0);
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        fpipe[i] <= fpipe[i-1];
      end
      max_q <= max_nx;
    end
  end

  // Sweep controller. All bus outputs are registered. The read address for
  // the k-th READ cycle is loaded on the edge that enters that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ox             <= '0;
      oy             <= '0;
      ch             <= '0;
      rcnt           <= '0;
      dcnt           <= '0;
      ecnt           <= '0;
      bus.ram_addr_r <= '0;
      bus.ram_en_r   <= 1'b0;
      bus.ram_addr_w <= '0;
      bus.ram_data_w <= '0;
      bus.ram_en     <= 1'b0;
      bus.ram_wea    <= 1'b0;
      bus.end_pool   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_pool) begin
            state          <= S_READ;
            ox             <= '0;
            oy             <= '0;
            ch             <= '0;
            rcnt           <= '0;
            bus.ram_en_r   <= 1'b1;
            bus.ram_addr_r <= '0;
          end
        end

        S_READ: begin
          if (rcnt == 2'd3) begin
            state        <= S_DRAIN;
            dcnt         <= '0;
            bus.ram_en_r <= 1'b0;
          end else begin
            rcnt           <= rcnt + 2'd1;
            bus.ram_addr_r <= base_cur + rd_offset(rcnt + 2'd1);
          end
        end

        S_DRAIN: begin
          if (dcnt == D_LAST) begin
            // The final sample is folded in here, so the written value
            // already includes it.
            state          <= S_WRITE;
            bus.ram_en     <= 1'b1;
            bus.ram_wea    <= 1'b1;
            bus.ram_addr_w <= OUT_BASE | out_idx;
            bus.ram_data_w <= max_nx;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        S_WRITE: begin
          bus.ram_en  <= 1'b0;
          bus.ram_wea <= 1'b0;
          if (last_win) begin
            state        <= S_DONE;
            ecnt         <= '0;
            bus.end_pool <= 1'b1;
          end else begin
            state          <= S_READ;
            ox             <= ox_nx;
            oy             <= oy_nx;
            ch             <= ch_nx;
            rcnt           <= '0;
            bus.ram_en_r   <= 1'b1;
            bus.ram_addr_r <= base_nx;
          end
        end

        S_DONE: begin
          if (ecnt == 2'd3) begin
            state        <= S_IDLE;
            bus.end_pool <= 1'b0;
          end else begin
            ecnt <= ecnt + 2'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool2_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool2_stage
//  Description : Self-checking bench for maxpool2_stage. It contains a RAM
//                model with 2-cycle read latency, a window-max reference
//                model, and a per-cycle bus checker.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maxpool2_stage;

  localparam int IN_DIM = 20;
  localparam int CH     = 16;
  localparam int OD     = IN_DIM / 2;
  localparam int NWIN   = OD * OD * CH;
  localparam int NWORDS = IN_DIM * IN_DIM * CH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maxpool2_stage_if bus ();

  maxpool2_stage #(
    .IN_DIM  (IN_DIM),
    .CH      (CH),
    .OUT_BASE(16'h8000),
    .RD_LAT  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic signed [7:0] mem      [NWORDS];
  logic [15:0]       exp_addr [NWIN];
  logic signed [7:0] exp_data [NWIN];
  logic [15:0]       rd_ref   [NWIN*4];
  logic [23:0]       wr_q [$];
  logic [15:0]       rd_q [$];

  int          wr_cnt        = 0;
  int          bursts        = 0;
  int          end_run       = 0;
  int          last_wr_cyc   = 0;
  int          first_at      = 0;
  bit          first_pending = 1'b0;
  logic [15:0] last_wr_addr  = '0;
  logic        prev_end      = 1'b0;
  logic [7:0]  d1            = '0;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic fail_msg(input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Read port: the address is registered in the RAM, and there is one more
  // output stage, so data appears 2 cycles after the address is visible.
  always @(posedge clk) begin
    if (bus.ram_en_r)
      d1 <= (int'(bus.ram_addr_r) < NWORDS) ? mem[int'(bus.ram_addr_r)] : 8'h00;
    bus.ram_data_r <= d1;
  end

  // Bus checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("wea_eq_en", int'(bus.ram_wea), int'(bus.ram_en));
      if (bus.ram_en_r) begin
        if (rd_q.size() == 0) begin
          fail_msg($sformatf("unexpected_read addr=0x%0h at cycle %0d", bus.ram_addr_r, cyc));
        end else begin
          check("rd_addr", int'(bus.ram_addr_r), int'(rd_q[0]));
          void'(rd_q.pop_front());
        end
      end
      if (bus.ram_en) begin
        check("wr_during_end", int'(bus.end_pool), 0);
        if (wr_q.size() == 0) begin
          fail_msg($sformatf("unexpected_write addr=0x%0h at cycle %0d", bus.ram_addr_w, cyc));
        end else begin
          check("wr_addr", int'(bus.ram_addr_w), int'(wr_q[0][23:8]));
          check("wr_data", int'($signed(bus.ram_data_w)), int'($signed(wr_q[0][7:0])));
          void'(wr_q.pop_front());
        end
        if (first_pending) begin
          check("first_wr_cycle", cyc, first_at);
          first_pending = 1'b0;
        end else begin
          check("wr_spacing", cyc - last_wr_cyc, 7);
        end
        last_wr_cyc  = cyc;
        last_wr_addr = bus.ram_addr_w;
        wr_cnt++;
      end
      if (bus.end_pool && !prev_end) begin
        bursts++;
        end_run = 0;
        check("end_rise_cycle", cyc, last_wr_cyc + 1);
        check("end_after_addr", int'(last_wr_addr), 16'h863F);
      end
      if (bus.end_pool) end_run++;
      if (!bus.end_pool && prev_end) check("end_len", end_run, 4);
      prev_end = bus.end_pool;
    end else begin
      prev_end = 1'b0;
    end
  end

  // Reference: fill RAM_0 and derive each window's reads and its max.
  task automatic build_model();
    int b, w, m, v;
    int idx [4];
    for (int i = 0; i < NWORDS; i++) mem[i] = 8'((i % 251) - 125);
    mem[0]  = 8'(-5);   mem[1]  = 8'(7);    mem[20] = 8'(3);    mem[21] = 8'(-128);
    mem[2]  = 8'(-128); mem[3]  = 8'(-1);   mem[22] = 8'(-128); mem[23] = 8'(-2);
    mem[4]  = 8'(-128); mem[5]  = 8'(-128); mem[24] = 8'(-128); mem[25] = 8'(-128);
    for (int c = 0; c < CH; c++)
      for (int y = 0; y < OD; y++)
        for (int x = 0; x < OD; x++) begin
          w = x + y * OD + c * OD * OD;
          b = 2 * x + 2 * y * IN_DIM + c * IN_DIM * IN_DIM;
          idx[0] = b; idx[1] = b + 1; idx[2] = b + IN_DIM; idx[3] = b + IN_DIM + 1;
          m = -1000;
          for (int k = 0; k < 4; k++) begin
            rd_ref[4*w + k] = 16'(idx[k]);
            v = mem[idx[k]];
            if (v > m) m = v;
          end
          exp_addr[w] = 16'(32768 + w);
          exp_data[w] = 8'(m);
        end
  endtask

  task automatic load_queues();
    wr_q.delete();
    rd_q.delete();
    for (int w = 0; w < NWIN; w++) wr_q.push_back({exp_addr[w], exp_data[w]});
    for (int r = 0; r < NWIN * 4; r++) rd_q.push_back(rd_ref[r]);
    wr_cnt = 0;
    bursts = 0;
  endtask

  task automatic pulse_start(input bit new_run);
    bus.start_pool = 1'b1;
    if (new_run) begin
      first_at      = cyc + 7;
      first_pending = 1'b1;
    end
    @(negedge clk);
    bus.start_pool = 1'b0;
  endtask

  task automatic wait_end_rise(input string tag);
    int n = 0;
    while (bus.end_pool !== 1'b1 && n < 12000) begin @(negedge clk); n++; end
    if (bus.end_pool !== 1'b1) fail_msg({tag, " end_pool rise timeout"});
  endtask

  task automatic wait_end_fall(input string tag);
    int n = 0;
    while (bus.end_pool !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    if (bus.end_pool !== 1'b0) fail_msg({tag, " end_pool fall timeout"});
  endtask

  task automatic finish_run(input string tag);
    check({tag, "_writes_left"}, wr_q.size(), 0);
    check({tag, "_reads_left"}, rd_q.size(), 0);
    check({tag, "_write_count"}, wr_cnt, NWIN);
    check({tag, "_bursts"}, bursts, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ram_addr_r"}, int'(bus.ram_addr_r), 0);
    check({tag, "_ram_en_r"},   int'(bus.ram_en_r),   0);
    check({tag, "_ram_addr_w"}, int'(bus.ram_addr_w), 0);
    check({tag, "_ram_data_w"}, int'(bus.ram_data_w), 0);
    check({tag, "_ram_en"},     int'(bus.ram_en),     0);
    check({tag, "_ram_wea"},    int'(bus.ram_wea),    0);
    check({tag, "_end_pool"},   int'(bus.end_pool),   0);
  endtask

  initial begin
    int s, n;
    rst_n          = 1'b0;
    bus.start_pool = 1'b0;
    build_model();

    // Hand-computed values that pin the reference model.
    check("pin_w0_addr",    int'(exp_addr[0]),    16'h8000);
    check("pin_w0_data",    int'(exp_data[0]),    7);
    check("pin_w1_addr",    int'(exp_addr[1]),    16'h8001);
    check("pin_w1_data",    int'(exp_data[1]),    -1);
    check("pin_w2_data",    int'(exp_data[2]),    -128);
    check("pin_w3_data",    int'(exp_data[3]),    -98);
    check("pin_w60_addr",   int'(exp_addr[60]),   16'h803C);
    check("pin_w60_data",   int'(exp_data[60]),   116);
    check("pin_last_addr",  int'(exp_addr[1599]), 16'h863F);
    check("pin_last_data",  int'(exp_data[1599]), -1);
    check("pin_last_rd",    int'(rd_ref[6399]),   6399);

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Run A: full sweep, a stray start at cycle 100, and a start during end_pool.
    load_queues();
    s = cyc;
    pulse_start(1'b1);
    while (cyc < s + 100) @(negedge clk);
    pulse_start(1'b0);
    wait_end_rise("runA");
    @(negedge clk);
    pulse_start(1'b0);
    wait_end_fall("runA");
    finish_run("runA");

    // Run B: restart one cycle after end_pool falls.
    @(negedge clk);
    load_queues();
    pulse_start(1'b1);
    wait_end_rise("runB");
    wait_end_fall("runB");
    finish_run("runB");

    // Run C: reset in window 300, then a clean rerun.
    @(negedge clk);
    load_queues();
    pulse_start(1'b1);
    n = 0;
    while (wr_cnt < 300 && n < 3000) begin @(negedge clk); n++; end
    if (wr_cnt < 300) fail_msg("runC write 300 timeout");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    wr_q.delete();
    rd_q.delete();
    first_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset_bursts", bursts, 0);
    check("midreset_writes", wr_cnt, 300);
    load_queues();
    pulse_start(1'b1);
    wait_end_rise("runC");
    wait_end_fall("runC");
    finish_run("runC");

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
